le_word_packer: RTL
===================

Name: le_word_packer

Overview:
- Upstream neighbour of the little-endian-to-big-endian converter.
- Collects a byte stream over a valid/ready handshake and packs each group of DATA_W/8 bytes into one little-endian word. The first byte received lands in bits [7:0].
- The packed word drives the converter's le_data_i.
- Supports early termination: a partial word is closed with byte_last_i, zero-padded, and tagged with its valid-byte count.

Parameters:
- DATA_W, 32, output word width. Must be a multiple of 8 and ≥16.
- BYTES, DATA_W/8, derived localparam: bytes per word.
- CNT_W, $clog2(BYTES)+1, derived localparam: width of the byte-count field.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- byte_valid_i  in  1  input byte valid.
- byte_ready_o  out  1  block can accept a byte this cycle.
- byte_data_i  in  8  input byte.
- byte_last_i  in  1  marks the final byte of a message. Only meaningful with byte_valid_i.
- word_valid_o  out  1  packed word valid.
- word_ready_i  in  1  downstream accepts the word.
- word_data_o  out  DATA_W  packed little-endian word.
- word_bytes_o  out  CNT_W  number of valid bytes in word_data_o (1..BYTES).
- word_last_o  out  1  word closes a message.

Behaviour:
- Internal state:
  - Accumulator acc[DATA_W-1:0].
  - Byte index idx in 0..BYTES-1.
  - One output holding register: word_data_o, word_bytes_o, word_last_o, word_valid_o.
- Reset (reset==0 at a clk edge):
  - acc=0, idx=0.
  - word_valid_o=0, word_data_o=0, word_bytes_o=0, word_last_o=0.
  - Any partial word is discarded. This applies mid-message as well.
- Handshakes:
  - byte_ready_o = !word_valid_o || word_ready_i (combinational). It must not depend on byte_valid_i.
  - Byte transfer happens when byte_valid_i && byte_ready_o.
  - Word transfer happens when word_valid_o && word_ready_i.
- Non-completing byte transfer (idx<BYTES-1 and byte_last_i==0):
  - acc[8*idx +: 8] <= byte_data_i; idx <= idx+1.
- Completing byte transfer (idx==BYTES-1 or byte_last_i==1), on the next edge:
  - word_data_o <= acc with byte_data_i merged at lane idx. Lanes above idx are 0.
  - word_bytes_o <= idx+1.
  - word_last_o <= byte_last_i.
  - word_valid_o <= 1.
  - acc <= 0, idx <= 0.
- Latency: word_valid_o rises 1 cycle after the completing byte transfer.
- Output stability: while word_valid_o==1 && word_ready_i==0, all word_* outputs hold stable and byte_ready_o==0.
- Word transfer with no completing byte in the same cycle: word_valid_o <= 0. The data, bytes and last fields hold their values.
- Simultaneous word transfer and completing byte transfer: the new word replaces the old one and word_valid_o stays 1. This gives sustained throughput of 1 byte/cycle.
- byte_last_i at idx==BYTES-1: produces a full word with word_bytes_o=BYTES and word_last_o=1.
- byte_valid_i==0: no state change other than word drain.
- Zero-length messages do not exist: byte_last_i always accompanies a real byte.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles with word_ready_i=1, DATA_W=32 -> one cycle after the 4th byte: word_data_o=0x44332211, word_bytes_o=4, word_last_o=0, word_valid_o high for exactly 1 cycle.
- Bytes 0xAA,0xBB with byte_last_i on 0xBB -> word_data_o=0x0000BBAA, word_bytes_o=2, word_last_o=1. Next message starts at lane 0.
- Word pending with word_ready_i=0 for 5 cycles while byte_valid_i=1 -> byte_ready_o=0, word_data_o stable, no bytes consumed. Raise word_ready_i -> streaming resumes with no byte lost or duplicated.
- 8 back-to-back bytes 0x01..0x08 with word_ready_i=1 -> 0x04030201 then 0x08070605, with zero bubble cycles on byte_ready_o.
- Bytes 0x01,0x02, then reset low for 1 cycle, then bytes 0x09,0x0A,0x0B,0x0C -> only word 0x0C0B0A09 is produced. All outputs read 0 in the cycle after reset.
- Single byte 0x5A with byte_last_i -> word_data_o=0x0000005A, word_bytes_o=1, word_last_o=1.

Source files
------------

// File: rtl/le_word_packer.sv
// le_word_packer: packs a valid/ready byte stream into little-endian words, first byte in bits [7:0];
// byte_last_i closes a partial word early, zero-padded and tagged with its byte count.
module le_word_packer #(
   parameter int DATA_W = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         byte_valid_i,
   output logic                         byte_ready_o,
   input  logic [7:0]                   byte_data_i,
   input  logic                         byte_last_i,
   output logic                         word_valid_o,
   input  logic                         word_ready_i,
   output logic [DATA_W-1:0]            word_data_o,
   output logic [$clog2(DATA_W/8):0]    word_bytes_o,
   output logic                         word_last_o
);
   localparam int BYTES = DATA_W / 8;
   localparam int CNT_W = $clog2(BYTES) + 1;
   localparam int IDX_W = $clog2(BYTES);
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] merged;
   logic [IDX_W-1:0]  idx;
   logic              byte_fire;
   logic              complete;
   assign byte_ready_o = !word_valid_o || word_ready_i;
   assign byte_fire    = byte_valid_i && byte_ready_o;
   assign complete     = byte_last_i || (idx == IDX_W'(BYTES - 1));
   // lanes above idx are already zero because acc is cleared whenever a word closes
   always_comb begin
      merged = acc;
      merged[8*idx +: 8] = byte_data_i;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc          <= '0;
         idx          <= '0;
         word_valid_o <= 1'b0;
         word_data_o  <= '0;
         word_bytes_o <= '0;
         word_last_o  <= 1'b0;
      end else begin
         if (word_valid_o && word_ready_i) word_valid_o <= 1'b0;
         if (byte_fire) begin
            if (complete) begin
               word_data_o  <= merged;
               word_bytes_o <= CNT_W'(idx) + CNT_W'(1);
               word_last_o  <= byte_last_i;
               word_valid_o <= 1'b1;
               acc          <= '0;
               idx          <= '0;
            end else begin
               acc <= merged;
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end
endmodule
